universal_shift_reg: RTL and testbench

//  Parametrised universal shift register: hold, shift right, shift left or parallel load, per cycle.

---
 rtl/universal_shift_reg.sv | 66 ++++++
 tb/tb_universal_shift_reg.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load each cycle,
// with a shift counter that pulses word_done after every WIDTH serial shifts.
module universal_shift_reg #(
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  localparam logic [1:0]    MODE_HOLD  = 2'b00;
  localparam logic [1:0]    MODE_RIGHT = 2'b01;
  localparam logic [1:0]    MODE_LEFT  = 2'b10;
  localparam logic [1:0]    MODE_LOAD  = 2'b11;
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q;
  logic             is_shift;

  assign is_shift = (mode == MODE_RIGHT) || (mode == MODE_LEFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= RESET_VAL;
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (en) begin
        case (mode)
          MODE_RIGHT: q <= {serial_in_r, q[WIDTH-1:1]};
          MODE_LEFT:  q <= {q[WIDTH-2:0], serial_in_l};
          MODE_LOAD:  q <= parallel_in;
          default:    q <= q;
        endcase
        // Both directions advance the same counter; a load restarts word framing.
        if (is_shift) begin
          if (shift_cnt == CNT_LAST) begin
            shift_cnt <= '0;
            word_done <= 1'b1;
          end else begin
            shift_cnt <= shift_cnt + CW'(1);
          end
        end else if (mode == MODE_LOAD) begin
          shift_cnt <= '0;
        end
      end
    end
  end

  assign parallel_out = q;
  assign serial_out_r = q[0];
  assign serial_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: a 4-bit instance checked against a reference model via a
// scoreboard queue, plus 8-bit and 2-bit instances for the parameter sweep.
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sr = 1'b0;
  logic       sl = 1'b0;
  logic [3:0] pin4 = '0;
  logic [7:0] pin8 = '0;
  logic [1:0] pin2 = '0;

  logic [3:0] q4;  logic [1:0] cnt4; logic done4, sor4, sol4;
  logic [7:0] q8;  logic [2:0] cnt8; logic done8, sor8, sol8;
  logic [1:0] q2;  logic       cnt2; logic done2, sor2, sol2;

  universal_shift_reg #(.WIDTH(4), .RESET_VAL(4'h0)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .serial_in_r(sr), .serial_in_l(sl),
    .parallel_in(pin4), .parallel_out(q4), .serial_out_r(sor4), .serial_out_l(sol4),
    .shift_cnt(cnt4), .word_done(done4));

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h5A)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .serial_in_r(sr), .serial_in_l(sl),
    .parallel_in(pin8), .parallel_out(q8), .serial_out_r(sor8), .serial_out_l(sol8),
    .shift_cnt(cnt8), .word_done(done8));

  universal_shift_reg #(.WIDTH(2), .RESET_VAL(2'b00)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .serial_in_r(sr), .serial_in_l(sl),
    .parallel_in(pin2), .parallel_out(q2), .serial_out_r(sor2), .serial_out_l(sol2),
    .shift_cnt(cnt2), .word_done(done2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q;
    logic [1:0] cnt;
    logic       done;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_q;
  logic [1:0] m_cnt;
  logic       m_done;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic model_reset();
    m_q    = 4'h0;
    m_cnt  = 2'd0;
    m_done = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus at the falling edge, predict the 4-bit result, and leave
  // the caller just after the following rising edge.
  task automatic drive4(input logic e_i, input logic [1:0] m_i, input logic sr_i,
                        input logic sl_i, input logic [3:0] p_i);
    exp_t x;
    @(negedge clk);
    en   = e_i;
    mode = m_i;
    sr   = sr_i;
    sl   = sl_i;
    pin4 = p_i;
    pin8 = {p_i, p_i};
    pin2 = p_i[1:0];
    m_done = 1'b0;
    if (e_i) begin
      if (m_i == 2'b01 || m_i == 2'b10) begin
        m_q = (m_i == 2'b01) ? {sr_i, m_q[3:1]} : {m_q[2:0], sl_i};
        if (m_cnt == 2'd3) begin
          m_cnt  = 2'd0;
          m_done = 1'b1;
        end else begin
          m_cnt = m_cnt + 2'd1;
        end
      end else if (m_i == 2'b11) begin
        m_q   = p_i;
        m_cnt = 2'd0;
      end
    end
    x = '{q: m_q, cnt: m_cnt, done: m_done};
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    model_reset();
    n_checks++;
    if ({q4, cnt4, done4} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_w4: q=%h cnt=%0d done=%b, want 0/0/0", q4, cnt4, done4);
    end
    n_checks++;
    if ({q8, cnt8, done8, q2, cnt2, done2} !== {8'h5A, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_w8_w2: q8=%h cnt8=%0d q2=%b cnt2=%0d, want 5a/0/00/0", q8, cnt8, q2, cnt2);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_siso();
    logic [3:0] exp_q [4] = '{4'h8, 4'hC, 4'h6, 4'hB};
    logic       bits  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_t x;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 2'b01, bits[i], 1'b0, 4'h0);
      x = sb.pop_front();
      n_checks++;
      if ({q4, cnt4, done4, sor4, sol4} !== {x.q, x.cnt, x.done, x.q[0], x.q[3]}) begin
        n_errors++;
        $display("FAIL siso_sb step %0d: q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, q4, cnt4, done4, x.q, x.cnt, x.done);
      end
      n_checks++;
      if (q4 !== exp_q[i] || done4 !== (i == 3)) begin
        n_errors++;
        $display("FAIL siso_q step %0d: q=%b done=%b, want q=%b done=%b", i, q4, done4, exp_q[i], (i == 3));
      end
    end
    drive4(1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
    x = sb.pop_front();
    n_checks++;
    if (done4 !== x.done || q4 !== x.q) begin
      n_errors++;
      $display("FAIL siso_after: q=%h done=%b, want q=%h done=%b", q4, done4, x.q, x.done);
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_q [4] = '{4'h1, 4'h2, 4'h5, 4'hB};
    logic       bits  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_t x;
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'h0);
    x = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 2'b10, 1'b0, bits[i], 4'h0);
      x = sb.pop_front();
      n_checks++;
      if ({q4, cnt4, done4, sor4, sol4} !== {x.q, x.cnt, x.done, x.q[0], x.q[3]}) begin
        n_errors++;
        $display("FAIL left_sb step %0d: q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, q4, cnt4, done4, x.q, x.cnt, x.done);
      end
      n_checks++;
      if (q4 !== exp_q[i] || sol4 !== (i == 3)) begin
        n_errors++;
        $display("FAIL left_q step %0d: q=%b sol=%b, want q=%b sol=%b", i, q4, sol4, exp_q[i], (i == 3));
      end
    end
  endtask

  task automatic test_load_unload();
    logic [3:0] exp_q   [5] = '{4'hA, 4'h5, 4'h2, 4'h1, 4'h0};
    logic       exp_sor [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   pulses = 0;
    exp_t x;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'hA);
      else        drive4(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
      x = sb.pop_front();
      pulses += int'(done4);
      n_checks++;
      if ({q4, cnt4, done4, sor4, sol4} !== {x.q, x.cnt, x.done, x.q[0], x.q[3]}) begin
        n_errors++;
        $display("FAIL unload_sb step %0d: q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, q4, cnt4, done4, x.q, x.cnt, x.done);
      end
      n_checks++;
      if (q4 !== exp_q[i] || sor4 !== exp_sor[i]) begin
        n_errors++;
        $display("FAIL unload_q step %0d: q=%h sor=%b, want q=%h sor=%b", i, q4, sor4, exp_q[i], exp_sor[i]);
      end
    end
    n_checks++;
    if (pulses != 1 || done4 !== 1'b1) begin
      n_errors++;
      $display("FAIL unload_pulses: got %0d (last done=%b), want 1 at last shift", pulses, done4);
    end
  endtask

  task automatic test_reset_midword();
    int   pulses = 0;
    exp_t x;
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'h0);
    x = sb.pop_front();
    for (int i = 0; i < 2; i++) begin
      drive4(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
      x = sb.pop_front();
    end
    n_checks++;
    if (cnt4 !== 2'd2 || q4 !== 4'hC) begin
      n_errors++;
      $display("FAIL midword_pre: q=%h cnt=%0d, want c/2", q4, cnt4);
    end
    rst = 1'b0;
    #2;
    model_reset();
    n_checks++;
    if ({q4, cnt4, done4} !== 7'b0) begin
      n_errors++;
      $display("FAIL midword_async: q=%h cnt=%0d done=%b, want 0/0/0", q4, cnt4, done4);
    end
    @(negedge clk);
    en = 1'b1; mode = 2'b01; sr = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({q4, cnt4, done4} !== 7'b0) begin
      n_errors++;
      $display("FAIL midword_held: q=%h cnt=%0d done=%b, want 0/0/0", q4, cnt4, done4);
    end
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
      x = sb.pop_front();
      pulses += int'(done4);
      n_checks++;
      if ({q4, cnt4, done4} !== {x.q, x.cnt, x.done} || done4 !== (i == 3)) begin
        n_errors++;
        $display("FAIL midword_after step %0d: q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, q4, cnt4, done4, x.q, x.cnt, x.done);
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL midword_pulses: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_hold_mixed();
    logic [1:0] seq_mode [13] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                                  2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    logic       seq_en   [13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       seq_bit  [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] want_q   [13] = '{4'h0, 4'h8, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1,
                                  4'h0, 4'h1, 4'h1, 4'h2, 4'h9};
    logic [1:0] want_cnt [13] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                  2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
    exp_t x;
    for (int i = 0; i < 13; i++) begin
      drive4(seq_en[i], seq_mode[i], seq_bit[i], seq_bit[i], 4'h0);
      x = sb.pop_front();
      n_checks++;
      if ({q4, cnt4, done4, sor4, sol4} !== {x.q, x.cnt, x.done, x.q[0], x.q[3]}) begin
        n_errors++;
        $display("FAIL hold_sb step %0d: q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, q4, cnt4, done4, x.q, x.cnt, x.done);
      end
      n_checks++;
      if (q4 !== want_q[i] || cnt4 !== want_cnt[i] || done4 !== (i == 9)) begin
        n_errors++;
        $display("FAIL hold_q step %0d: q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, q4, cnt4, done4, want_q[i], want_cnt[i], (i == 9));
      end
    end
  endtask

  task automatic test_back_to_back();
    int   pulses = 0;
    exp_t x;
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'h0);
    x = sb.pop_front();
    for (int i = 0; i < 12; i++) begin
      drive4(1'b1, (i % 3 == 0) ? 2'b10 : 2'b01, 1'($urandom), 1'($urandom), 4'h0);
      x = sb.pop_front();
      pulses += int'(done4);
      n_checks++;
      if ({q4, cnt4, done4, sor4, sol4} !== {x.q, x.cnt, x.done, x.q[0], x.q[3]} ||
          done4 !== (i % 4 == 3)) begin
        n_errors++;
        $display("FAIL b2b step %0d: q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, q4, cnt4, done4, x.q, x.cnt, x.done);
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_errors++;
      $display("FAIL b2b_pulses: got %0d, want 3", pulses);
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0] pat = 8'hC3;
    exp_t x;
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    #2;
    model_reset();
    n_checks++;
    if (q8 !== 8'h5A || cnt8 !== 3'd0 || done8 !== 1'b0 || q2 !== 2'b00) begin
      n_errors++;
      $display("FAIL sweep_reset: q8=%h cnt8=%0d done8=%b q2=%b, want 5a/0/0/00", q8, cnt8, done8, q2);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive4(1'b1, 2'b01, pat[i], 1'b0, 4'h0);
      x = sb.pop_front();
      n_checks++;
      if ({q4, cnt4, done4} !== {x.q, x.cnt, x.done}) begin
        n_errors++;
        $display("FAIL sweep_w4 step %0d: q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, q4, cnt4, done4, x.q, x.cnt, x.done);
      end
      n_checks++;
      if (done8 !== (i == 7) || cnt8 !== 3'((i + 1) % 8)) begin
        n_errors++;
        $display("FAIL sweep_w8 step %0d: cnt=%0d done=%b, want cnt=%0d done=%b",
                 i, cnt8, done8, (i + 1) % 8, (i == 7));
      end
      n_checks++;
      if (done2 !== (i % 2 == 1) || cnt2 !== 1'((i + 1) % 2)) begin
        n_errors++;
        $display("FAIL sweep_w2 step %0d: cnt=%0d done=%b, want cnt=%0d done=%b",
                 i, cnt2, done2, (i + 1) % 2, (i % 2 == 1));
      end
    end
    n_checks++;
    if (q8 !== pat || q2 !== pat[7:6]) begin
      n_errors++;
      $display("FAIL sweep_word: q8=%h q2=%b, want q8=%h q2=%b", q8, q2, pat, pat[7:6]);
    end
  endtask

  initial begin
    test_reset();
    test_siso();
    test_shift_left();
    test_load_unload();
    test_reset_midword();
    test_hold_mixed();
    test_back_to_back();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
